// File: rtl/ser5_pkg.sv
// Shared types and constants for the 5-bit serializer and its select sequencer.
package ser5_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned NBITS    = 5;
  localparam logic [2:0]  SEL_IDLE = 3'd5;
  localparam logic [2:0]  SEL_LAST = 3'd4;

endpackage

// File: rtl/mux5.sv
// 5:1 single-bit multiplexer; any select code above 4 forces the output to 0.
module mux5 (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       d4,
  input  logic [2:0] s,
  output logic       y
);

  // Select one data bit, park at 0 for the idle codes.
  always_comb begin
    y = 1'b0;
    case (s)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/ser5_sequencer.sv
// Drives the mux5 select through 0..4 to serialize a captured 5-bit word, LSB first,
// holding each bit for TICKS_PER_BIT clocks. Select parks on 5 (output 0) when idle.
module ser5_sequencer
  import ser5_pkg::*;
#(
  parameter int unsigned TICKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] din,
  output logic             ready,
  output logic [2:0]       sel,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             done
);

  localparam int unsigned    TickW   = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICKS_PER_BIT - 1);

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [NBITS-1:0]   hold_q, hold_d;
  logic [TickW-1:0]   tick_q, tick_d;

  // State, select, hold word and tick counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= SEL_IDLE;
      hold_q  <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic: capture on start, step select every TICKS_PER_BIT clocks.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    tick_d  = tick_q;
    case (state_q)
      IDLE: begin
        sel_d = SEL_IDLE;
        if (start) begin
          hold_d  = din;
          sel_d   = 3'd0;
          tick_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_q == TickMax) begin
          tick_d = '0;
          if (sel_q == SEL_LAST) begin
            sel_d   = SEL_IDLE;
            state_d = DONE;
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      DONE: begin
        sel_d   = SEL_IDLE;
        tick_d  = '0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = SEL_IDLE;
        tick_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Status flags decode straight from the registered state, so reset acts at once.
  always_comb begin
    ready      = (state_q == IDLE);
    sout_valid = (state_q == SHIFT);
    last       = (state_q == SHIFT) && (sel_q == SEL_LAST);
    done       = (state_q == DONE);
    sel        = sel_q;
  end

  mux5 u_mux5 (
    .d0 (hold_q[0]),
    .d1 (hold_q[1]),
    .d2 (hold_q[2]),
    .d3 (hold_q[3]),
    .d4 (hold_q[4]),
    .s  (sel_q),
    .y  (sout)
  );

endmodule

// File: tb/tb_ser5_sequencer.sv
// Directed bench for ser5_sequencer: one instance with TICKS_PER_BIT=1, one with 4.
module tb_ser5_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start4;
  logic [4:0] din;

  logic       r1, so1, v1, l1, d1;
  logic [2:0] sel1;
  logic       r4, so4, v4, l4, d4;
  logic [2:0] sel4;

  int checks   = 0;
  int failures = 0;

  logic       mon_en = 1'b0;
  int         bad_sel = 0;
  int         bad_out = 0;

  always #5 clk = ~clk;

  ser5_sequencer #(.TICKS_PER_BIT(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start1),
    .din        (din),
    .ready      (r1),
    .sel        (sel1),
    .sout       (so1),
    .sout_valid (v1),
    .last       (l1),
    .done       (d1)
  );

  ser5_sequencer #(.TICKS_PER_BIT(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .start      (start4),
    .din        (din),
    .ready      (r4),
    .sel        (sel4),
    .sout       (so4),
    .sout_valid (v4),
    .last       (l4),
    .done       (d4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out1(input string tag, input logic rdy, input logic [2:0] s, input logic o,
                          input logic v, input logic l, input logic dn);
    chk({tag, " ready"}, 32'(r1), 32'(rdy));
    chk({tag, " sel"},   32'(sel1), 32'(s));
    chk({tag, " sout"},  32'(so1), 32'(o));
    chk({tag, " valid"}, 32'(v1), 32'(v));
    chk({tag, " last"},  32'(l1), 32'(l));
    chk({tag, " done"},  32'(d1), 32'(dn));
  endtask

  task automatic chk_out4(input string tag, input logic rdy, input logic [2:0] s, input logic o,
                          input logic v, input logic l, input logic dn);
    chk({tag, " ready"}, 32'(r4), 32'(rdy));
    chk({tag, " sel"},   32'(sel4), 32'(s));
    chk({tag, " sout"},  32'(so4), 32'(o));
    chk({tag, " valid"}, 32'(v4), 32'(v));
    chk({tag, " last"},  32'(l4), 32'(l));
    chk({tag, " done"},  32'(d4), 32'(dn));
  endtask

  // Watch for illegal select codes and a non-zero output on the idle code.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sel1 > 3'd5 || sel4 > 3'd5) bad_sel++;
      if ((sel1 == 3'd5 && so1) || (sel4 == 3'd5 && so4)) bad_out++;
      if ((!v1 && so1) || (!v4 && so4)) bad_out++;
    end
  end

  // Run one T=1 frame of word w and check every cycle through ready.
  task automatic frame1(input string tag, input logic [4:0] w);
    din    = w;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk_out1($sformatf("%s c%0d", tag, c), 1'b0, 3'(c - 1), w[c-1], 1'b1, c == 5, 1'b0);
      @(negedge clk);
    end
    chk_out1($sformatf("%s c6", tag), 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_out1($sformatf("%s c7", tag), 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [4:0] w;
  logic [4:0] cap;
  int         n_done, n_valid, n_busy;

  initial begin
    reset  = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    din    = 5'd0;

    // Asynchronous reset before the first clock edge.
    #2 reset = 1'b1;
    #1;
    chk_out1("rst1", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out4("rst4", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // T=1 frame: sout 0,1,1,0,1.
    frame1("t1", 5'b10110);

    // T=4 frame: each bit held 4 cycles, done in cycle 21.
    w      = 5'b01001;
    din    = w;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      chk_out4($sformatf("t4 c%0d", c), 1'b0, 3'((c - 1) / 4), w[(c-1)/4], 1'b1, c > 16, 1'b0);
      @(negedge clk);
    end
    chk_out4("t4 c21", 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_out4("t4 c22", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start held high, din toggled every cycle.
    w      = 5'b00111;
    din    = w;
    start4 = 1'b1;
    cap    = 5'd0;
    @(negedge clk);
    for (int c = 1; c <= 22; c++) begin
      if (c <= 20) begin
        chk($sformatf("hold c%0d sout", c), 32'(so4), 32'(w[(c-1)/4]));
        chk($sformatf("hold c%0d sel", c), 32'(sel4), 32'((c - 1) / 4));
        chk($sformatf("hold c%0d ready", c), 32'(r4), 32'd0);
      end else if (c == 21) begin
        chk("hold c21 done", 32'(d4), 32'd1);
        chk("hold c21 ready", 32'(r4), 32'd0);
      end else begin
        chk("hold c22 ready", 32'(r4), 32'd1);
        chk("hold c22 valid", 32'(v4), 32'd0);
      end
      din = ~din;
      if (c == 22) cap = din;
      @(negedge clk);
    end
    chk("hold c23 valid", 32'(v4), 32'd1);
    chk("hold c23 sel", 32'(sel4), 32'd0);
    chk("hold c23 sout", 32'(so4), 32'(cap[0]));
    start4 = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;

    // Mid-frame reset during bit 2.
    din    = 5'b11111;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid c10 sel", 32'(sel4), 32'd2);
    chk("mid c10 sout", 32'(so4), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_out4("mid rst", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    n_done  = 0;
    n_valid = 0;
    n_busy  = 0;
    repeat (30) begin
      @(negedge clk);
      if (d4) n_done++;
      if (v4) n_valid++;
      if (!r4) n_busy++;
    end
    chk("mid done pulses", 32'(n_done), 32'd0);
    chk("mid valid cycles", 32'(n_valid), 32'd0);
    chk("mid busy cycles", 32'(n_busy), 32'd0);

    // Boundary words on the T=1 instance.
    frame1("ones", 5'b11111);
    @(negedge clk);
    frame1("zeros", 5'b00000);
    @(negedge clk);

    chk("sel range", 32'(bad_sel), 32'd0);
    chk("idle sout", 32'(bad_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
